// File: rtl/cache_fill_fsm_if.sv
// Memory-side read bus of the cache block fill engine.
// Master issues word reads; slave returns data in request order.
interface cache_fill_fsm_if;
   logic        mem_read_req;
   logic [15:0] memory_address;
   logic [15:0] memory_data;
   logic        memory_data_valid;

   modport master (
      output mem_read_req,
      output memory_address,
      input  memory_data,
      input  memory_data_valid
   );

   modport slave (
      input  mem_read_req,
      input  memory_address,
      output memory_data,
      output memory_data_valid
   );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: pipelined block read, data-array steering, tag write.
// Optional miss statistics counter enabled by defining CACHE_FILL_STATS_EN.
module cache_fill_fsm #(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int OFF_W           = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               miss_detected,
   input  logic [15:0]        miss_address,
   cache_fill_fsm_if.master   mem,
   output logic               fsm_busy,
   output logic               write_data_array,
   output logic [OFF_W-1:0]   word_offset,
   output logic [15:0]        fill_data,
`ifdef CACHE_FILL_STATS_EN
   output logic               write_tag_array,
   output logic [15:0]        miss_count
`else
   output logic               write_tag_array
`endif
);

   typedef enum logic {
      IDLE,
      FILL
   } state_e;

   localparam logic [OFF_W:0] NWORDS = (OFF_W+1)'(WORDS_PER_BLOCK);
   localparam logic [OFF_W:0] LAST   = NWORDS - 1'b1;

   state_e         state_q, state_d;
   logic [OFF_W:0] issue_q, issue_d;
   logic [OFF_W:0] recv_q, recv_d;
   logic [15:0]    base_q, base_d;

   logic           req;
   logic [15:0]    addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         issue_q <= '0;
         recv_q  <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         issue_q <= issue_d;
         recv_q  <= recv_d;
         base_q  <= base_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      issue_d          = issue_q;
      recv_d           = recv_q;
      base_d           = base_q;
      fsm_busy         = 1'b0;
      req              = 1'b0;
      addr             = '0;
      write_data_array = 1'b0;
      word_offset      = '0;
      fill_data        = '0;
      write_tag_array  = 1'b0;
      unique case (state_q)
         IDLE: begin
            fsm_busy = miss_detected;
            if (miss_detected) begin
               base_d  = {miss_address[15:OFF_W+1], {(OFF_W+1){1'b0}}};
               issue_d = '0;
               recv_d  = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            fsm_busy    = 1'b1;
            addr        = base_q + {{(14-OFF_W){1'b0}}, issue_q, 1'b0};
            word_offset = recv_q[OFF_W-1:0];
            if (issue_q < NWORDS) begin
               req     = 1'b1;
               issue_d = issue_q + 1'b1;
            end
            // Returns beyond the block are dropped; counters never wrap.
            if (mem.memory_data_valid && (recv_q < NWORDS)) begin
               write_data_array = 1'b1;
               fill_data        = mem.memory_data;
               recv_d           = recv_q + 1'b1;
               if (recv_q == LAST) begin
                  write_tag_array = 1'b1;
                  state_d         = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem.mem_read_req   = req;
   assign mem.memory_address = addr;

`ifdef CACHE_FILL_STATS_EN
   logic [15:0] miss_count_q, miss_count_d;

   always_comb begin
      miss_count_d = miss_count_q;
      if ((state_q == IDLE) && miss_detected && (miss_count_q != 16'hFFFF))
         miss_count_d = miss_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) miss_count_q <= '0;
      else        miss_count_q <= miss_count_d;
   end

   assign miss_count = miss_count_q;
`endif

endmodule
